// File: rtl/data_mem_mmio_if.sv
// Load/store bus between the core and the data memory.
// Master drives the access; slave returns registered load data and error.
interface data_mem_mmio_if;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;

    modport master (
        output we, size, addr, wd,
        input  rd, err
    );

    modport slave (
        input  we, size, addr, wd,
        output rd, err
    );
endinterface

// File: rtl/data_mem_mmio.sv
// Data RAM plus MMIO window (OUT regs, synchronised IN ports, EDGE capture).
// EDGE capture is built only when DMEM_EDGE_CAPTURE_EN is defined.
module data_mem_mmio #(
    parameter int          DEPTH   = 1024,
    parameter int          N_OUT   = 1,
    parameter int          N_IN    = 1,
    parameter logic [31:0] IO_BASE = 32'hFFFF0000
) (
    input  logic                clk,
    input  logic                rst_n,
    data_mem_mmio_if.slave      bus,
    output logic [N_OUT*32-1:0] salidas,
    input  logic [N_IN*32-1:0]  entradas
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]        mem [DEPTH];
    logic [31:0]        out_q [N_OUT];
    logic [31:0]        out_d [N_OUT];
    logic [N_IN*32-1:0] s1_q, s2_q;
    logic [31:0]        rd_q, rd_d;
    logic               err_q, err_d;

    logic        io_win, ram_hit, out_hit, in_hit, edge_hit;
    logic        mis, wen;
    logic [13:0] wsel;
    logic [4:0]  pidx;
    logic [3:0]  be;
    logic [31:0] wdl, bmask;
    logic [AW-1:0] ridx;

    assign wsel    = bus.addr[15:2];
    assign pidx    = bus.addr[6:2];
    assign ridx    = bus.addr[AW+1:2];
    assign io_win  = bus.addr[31:16] == IO_BASE[31:16];
    assign ram_hit = bus.addr[31:AW+2] == '0;
    assign out_hit = io_win && (wsel < 14'(N_OUT));
    assign in_hit  = io_win && (wsel >= 14'd32) && (wsel < 14'(32 + N_IN));

`ifdef DMEM_EDGE_CAPTURE_EN
    assign edge_hit = io_win && (wsel >= 14'd64) && (wsel < 14'(64 + N_IN));
`else
    assign edge_hit = 1'b0;
`endif

    always_comb begin
        mis = 1'b0;
        be  = 4'b0000;
        wdl = bus.wd;
        unique case (bus.size)
            2'b00: begin
                be  = 4'b0001 << bus.addr[1:0];
                wdl = {4{bus.wd[7:0]}};
            end
            2'b01: begin
                mis = bus.addr[0];
                be  = bus.addr[1] ? 4'b1100 : 4'b0011;
                wdl = {2{bus.wd[15:0]}};
            end
            2'b10: begin
                mis = |bus.addr[1:0];
                be  = 4'b1111;
            end
            default: mis = 1'b1;
        endcase
    end

    assign bmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign err_d = mis | ~(ram_hit | out_hit | in_hit | edge_hit);
    assign wen   = bus.we & ~err_d;

    // No reset on the array; a store seen while reset is low is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && wen && ram_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[ridx][8*b +: 8] <= wdl[8*b +: 8];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_OUT; i++) begin
            out_d[i] = out_q[i];
            if (wen && out_hit && pidx == 5'(i))
                out_d[i] = (out_q[i] & ~bmask) | (wdl & bmask);
        end
    end

    always_comb begin
        for (int i = 0; i < N_OUT; i++) salidas[32*i +: 32] = out_q[i];
    end

`ifdef DMEM_EDGE_CAPTURE_EN
    logic [N_IN*32-1:0] hist_q, edge_q, edge_d, clr;

    // Set has priority over a same-cycle write-1-to-clear.
    always_comb begin
        clr = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (wen && edge_hit && pidx == 5'(i))
                clr[32*i +: 32] = wdl & bmask;
        end
        edge_d = (edge_q & ~clr) | (s2_q & ~hist_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            edge_q <= '0;
        end else begin
            hist_q <= s2_q;
            edge_q <= edge_d;
        end
    end
`endif

    always_comb begin
        rd_d = '0;
        if (ram_hit) rd_d = mem[ridx];
        for (int i = 0; i < N_OUT; i++) begin
            if (out_hit && pidx == 5'(i)) rd_d = out_q[i];
        end
        for (int i = 0; i < N_IN; i++) begin
            if (in_hit && pidx == 5'(i)) rd_d = s2_q[32*i +: 32];
`ifdef DMEM_EDGE_CAPTURE_EN
            if (edge_hit && pidx == 5'(i)) rd_d = edge_q[32*i +: 32];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            err_q <= 1'b0;
            s1_q  <= '0;
            s2_q  <= '0;
            for (int i = 0; i < N_OUT; i++) out_q[i] <= '0;
        end else begin
            rd_q  <= rd_d;
            err_q <= err_d;
            s1_q  <= entradas;
            s2_q  <= s1_q;
            for (int i = 0; i < N_OUT; i++) out_q[i] <= out_d[i];
        end
    end

    assign bus.rd  = rd_q;
    assign bus.err = err_q;
endmodule
